mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multi-cycle control sequencer for the MIPS datapath. It supports the same instruction subset as the single-cycle decoder: R-type, lw, sw and beq. It steps each instruction through fetch, decode, execute, memory and write-back states, issuing per-cycle datapath control signals. It stalls on a shared instruction/data memory ready handshake and reports retired and illegal instructions.

## Interface
Parameters:
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- opcode  in  6  instruction[31:26] taken from the instruction register (IR).
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead, MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  load IR.
- MemtoReg, RegDst, RegWrite  out  1 each  register file controls.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct field.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse when the opcode is unsupported.
- retired_cnt  out  CNT_W  count of retired instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, plus JUMP when the macro is defined.
- FETCH
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite assert only in the cycle mem_ready=1; that cycle also advances to DECODE.
  - Otherwise FETCH holds with MemRead held high.
- DECODE
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 to precompute the branch target.
  - Dispatches on opcode: 000000 → EXEC; 100011 or 101011 → MEMADR; 000100 → BRANCH.
  - Any other opcode pulses illegal_op and returns to FETCH; nothing retires.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Retires, then goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready, then retires and goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Retires, then goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Retires, then goes to FETCH.
- Signals not listed for a state are 0.
- Retirement: instr_done pulses in the retiring cycle, and retired_cnt increments on the same edge.
- retired_cnt wraps from all-ones to 0 with no flag.

## Timing
- Reset
  - rst_n=0 sampled on an edge → state=FETCH, retired_cnt=0.
  - While rst_n=0, every output is forced to 0, including FETCH's MemRead.
  - The first cycle after release is FETCH with MemRead=1.
  - Reset mid-instruction abandons it with no retire and no pulse.
- Zero-wait latencies, FETCH entry to the next FETCH: R-type 4, lw 5, sw 4, beq 3, illegal 2 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready is ignored in all other states.
- Outputs are combinational from state only (Moore), except IRWrite and PCWrite in FETCH, which are gated by mem_ready.
- opcode is sampled only in DECODE and MEMADR; the IR is stable there.

## Configuration
- MIPS_CTRL_JUMP_EN defined:
  - Opcode 000010 in DECODE → JUMP.
  - JUMP drives PCWrite=1, PCSource=10, retires, then goes to FETCH. Latency is 3 cycles.
- MIPS_CTRL_JUMP_EN undefined:
  - Opcode 000010 is illegal.
  - JUMP state is absent.
  - PCSource never takes 10.

## Structure
- Package mips_pkg:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J;
  - state enum typedef ctrl_state_t;
  - ALUOp and ALUSrcB encoding constants.
- One sub-module, mips_ctrl_outdec: purely combinational state + mem_ready → control-signal decode.
- The top level keeps the state register, next-state logic and counter.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → all outputs 0 during reset; the cycle after release shows MemRead=1, IorD=0, retired_cnt=0.
- R-type 0x014B4820 with mem_ready=1 → FETCH, DECODE, EXEC (ALUOp=10), ALUWB (RegWrite=1, RegDst=1). instr_done is seen at cycle 4 and retired_cnt=1.
- lw 0x8D280004 with mem_ready low for 2 cycles in MEMRD → total 7 cycles; MEMWB drives MemtoReg=1, RegWrite=1.
- sw 0xAD280004 then beq 0x112A0002 → MEMWR drives MemWrite=1, IorD=1; BRANCH drives PCWriteCond=1, ALUOp=01, PCSource=01; retired_cnt=2.
- Opcode 0x3F, and 000010 with the macro undefined → illegal_op pulses in DECODE, there is no instr_done, and the next cycle is FETCH. With the macro defined, 000010 gives PCWrite=1, PCSource=10.
- Assert rst_n=0 in MEMRD with mem_ready=0, and separately preload retired_cnt at all-ones then retire one instruction → the reset case returns to FETCH with no instr_done; the preloaded counter wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multi-cycle MIPS control sequencer.
//   - opcode constants for the supported instruction subset
//   - ctrl_state_t: sequencer state encoding
//   - ALUOp / ALUSrcB / PCSource encodings
// Optional feature macro: MIPS_CTRL_JUMP_EN adds the JUMP state (opcode 000010).
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] ALUSRCB_B     = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
`ifdef MIPS_CTRL_JUMP_EN
      BRANCH = 4'd8,
      JUMP   = 4'd9
`else
      BRANCH = 4'd8
`endif
   } ctrl_state_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: purely combinational decode of sequencer state (plus
// mem_ready for the FETCH-cycle IR/PC loads) into datapath control signals.
// Ports:
//   state, mem_ready            : current state, memory handshake
//   pc_write .. pc_source       : datapath controls (same meaning as the
//                                 top-level PCWrite .. PCSource outputs)
// Optional feature macro: MIPS_CTRL_JUMP_EN (JUMP state decode).
module mips_ctrl_outdec
   import mips_pkg::*;
(
   input  ctrl_state_t state,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        ior_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source
);

   // Moore decode of per-state controls; anything not driven stays 0.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ior_d         = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = ALUSRCB_B;
      alu_op        = ALUOP_ADD;
      pc_source     = PCSRC_ALU;
      case (state)
         FETCH: begin
            // PC+4 computed every FETCH cycle but only committed with the IR
            mem_read  = 1'b1;
            alu_src_b = ALUSRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE: begin
            // speculative branch target into ALUOut
            alu_src_b = ALUSRCB_IMMSH;
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUSRCB_IMM;
         end
         MEMRD: begin
            mem_read = 1'b1;
            ior_d    = 1'b1;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEMWR: begin
            mem_write = 1'b1;
            ior_d     = 1'b1;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
`ifdef MIPS_CTRL_JUMP_EN
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
`endif
         default: begin
            pc_write = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS control sequencer (R-type, lw, sw,
// beq; optionally j). Holds the state register, next-state logic and the
// retired-instruction counter; control decode lives in mips_ctrl_outdec.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   opcode            : IR[31:26], used in DECODE and MEMADR only
//   mem_ready         : shared memory completes access this cycle
//   PCWrite .. PCSource : datapath controls
//   instr_done        : one-cycle pulse in the retiring cycle
//   illegal_op        : one-cycle pulse in DECODE for unsupported opcodes
//   retired_cnt       : wrapping count of retired instructions
// Optional feature macro: MIPS_CTRL_JUMP_EN enables opcode 000010 (JUMP).
module mips_multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic             instr_done,
   output logic             illegal_op,
   output logic [CNT_W-1:0] retired_cnt
);

   ctrl_state_t      state_r;
   ctrl_state_t      next_s;
   logic [CNT_W-1:0] retired_cnt_r;
   logic             retire_s;
   logic             illegal_s;

   logic       pc_write_s, pc_write_cond_s, ior_d_s, mem_read_s, mem_write_s;
   logic       ir_write_s, mem_to_reg_s, reg_dst_s, reg_write_s, alu_src_a_s;
   logic [1:0] alu_src_b_s, alu_op_s, pc_source_s;

   // State register and retired counter; reset wins over a same-cycle retire.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= FETCH;
         retired_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= next_s;
         if (retire_s) begin
            retired_cnt_r <= retired_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            retired_cnt_r <= retired_cnt_r;
         end
      end
   end

   // Next-state, retire and illegal-opcode logic.
   always_comb begin
      next_s    = state_r;
      retire_s  = 1'b0;
      illegal_s = 1'b0;
      case (state_r)
         FETCH: begin
            if (mem_ready) next_s = DECODE;
            else           next_s = FETCH;
         end
         DECODE: begin
            case (opcode)
               OP_RTYPE:     next_s = EXEC;
               OP_LW, OP_SW: next_s = MEMADR;
               OP_BEQ:       next_s = BRANCH;
`ifdef MIPS_CTRL_JUMP_EN
               OP_J:         next_s = JUMP;
`endif
               default: begin
                  illegal_s = 1'b1;
                  next_s    = FETCH;
               end
            endcase
         end
         MEMADR: begin
            // only lw/sw reach here, so anything other than lw is a store
            if (opcode == OP_LW) next_s = MEMRD;
            else                 next_s = MEMWR;
         end
         MEMRD: begin
            if (mem_ready) next_s = MEMWB;
            else           next_s = MEMRD;
         end
         MEMWB: begin
            retire_s = 1'b1;
            next_s   = FETCH;
         end
         MEMWR: begin
            if (mem_ready) begin
               retire_s = 1'b1;
               next_s   = FETCH;
            end else begin
               next_s = MEMWR;
            end
         end
         EXEC:  next_s = ALUWB;
         ALUWB: begin
            retire_s = 1'b1;
            next_s   = FETCH;
         end
         BRANCH: begin
            retire_s = 1'b1;
            next_s   = FETCH;
         end
`ifdef MIPS_CTRL_JUMP_EN
         JUMP: begin
            retire_s = 1'b1;
            next_s   = FETCH;
         end
`endif
         default: next_s = FETCH;
      endcase
   end

   mips_ctrl_outdec u_outdec (
      .state         (state_r),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write_s),
      .pc_write_cond (pc_write_cond_s),
      .ior_d         (ior_d_s),
      .mem_read      (mem_read_s),
      .mem_write     (mem_write_s),
      .ir_write      (ir_write_s),
      .mem_to_reg    (mem_to_reg_s),
      .reg_dst       (reg_dst_s),
      .reg_write     (reg_write_s),
      .alu_src_a     (alu_src_a_s),
      .alu_src_b     (alu_src_b_s),
      .alu_op        (alu_op_s),
      .pc_source     (pc_source_s)
   );

   // Reset is synchronous, so outputs are masked while rst_n is low to keep
   // the memory and register file quiet before the state register clears.
   assign PCWrite     = rst_n & pc_write_s;
   assign PCWriteCond = rst_n & pc_write_cond_s;
   assign IorD        = rst_n & ior_d_s;
   assign MemRead     = rst_n & mem_read_s;
   assign MemWrite    = rst_n & mem_write_s;
   assign IRWrite     = rst_n & ir_write_s;
   assign MemtoReg    = rst_n & mem_to_reg_s;
   assign RegDst      = rst_n & reg_dst_s;
   assign RegWrite    = rst_n & reg_write_s;
   assign ALUSrcA     = rst_n & alu_src_a_s;
   assign ALUSrcB     = rst_n ? alu_src_b_s : 2'b00;
   assign ALUOp       = rst_n ? alu_op_s    : 2'b00;
   assign PCSource    = rst_n ? pc_source_s : 2'b00;
   assign instr_done  = rst_n & retire_s;
   assign illegal_op  = rst_n & illegal_s;
   assign retired_cnt = rst_n ? retired_cnt_r : {CNT_W{1'b0}};

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl. One row per clock cycle:
// inputs are driven on the falling edge, outputs compared 1 ns later.
// A second instance with a 2-bit counter exercises counter wrap-around.
module tb_mips_multicycle_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT 1 (CNT_W = 32)
   logic        rst_n = 1'b0;
   logic [5:0]  opcode = 6'b000000;
   logic        mem_ready = 1'b0;
   logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0]  ALUSrcB, ALUOp, PCSource;
   logic        instr_done, illegal_op;
   logic [31:0] retired_cnt;

   mips_multicycle_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
      .retired_cnt(retired_cnt)
   );

   // DUT 2 (CNT_W = 2) for the wrap check
   logic        rst_n2 = 1'b0;
   logic [5:0]  opcode2 = 6'b000100;
   logic        mem_ready2 = 1'b1;
   logic        w_pcw, w_pcwc, w_iord, w_mrd, w_mwr, w_irw, w_m2r, w_rdst;
   logic        w_rwr, w_srca, w_done, w_ill;
   logic [1:0]  w_srcb, w_aluop, w_pcsrc;
   logic [1:0]  w_cnt;

   mips_multicycle_ctrl #(.CNT_W(2)) dut_wrap (
      .clk(clk), .rst_n(rst_n2), .opcode(opcode2), .mem_ready(mem_ready2),
      .PCWrite(w_pcw), .PCWriteCond(w_pcwc), .IorD(w_iord),
      .MemRead(w_mrd), .MemWrite(w_mwr), .IRWrite(w_irw),
      .MemtoReg(w_m2r), .RegDst(w_rdst), .RegWrite(w_rwr),
      .ALUSrcA(w_srca), .ALUSrcB(w_srcb), .ALUOp(w_aluop),
      .PCSource(w_pcsrc), .instr_done(w_done), .illegal_op(w_ill),
      .retired_cnt(w_cnt)
   );

   // Expected bundle:
   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
   //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],instr_done,illegal_op}
   localparam logic [17:0] E_RST        = 18'b0;
   localparam logic [17:0] E_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
   localparam logic [17:0] E_FETCH_GO   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
   localparam logic [17:0] E_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
   localparam logic [17:0] E_DECODE_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b1};
   localparam logic [17:0] E_MEMADR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
   localparam logic [17:0] E_MEMRD      = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
   localparam logic [17:0] E_MEMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
   localparam logic [17:0] E_MEMWR_WAIT = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
   localparam logic [17:0] E_MEMWR_GO   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
   localparam logic [17:0] E_EXEC       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0};
   localparam logic [17:0] E_ALUWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
   localparam logic [17:0] E_BRANCH     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0};
   localparam logic [17:0] E_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0};

   localparam logic [5:0] RT  = 6'b000000;
   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] SW  = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100;
   localparam logic [5:0] JMP = 6'b000010;
   localparam logic [5:0] BAD = 6'b111111;

   typedef struct {
      logic        rst;
      logic        mr;
      logic [5:0]  op;
      logic [17:0] exp;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic add(input logic rst, input logic mr, input logic [5:0] op,
                      input logic [17:0] exp, input logic [31:0] cnt);
      vec_t v;
      v.rst = rst; v.mr = mr; v.op = op; v.exp = exp; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
      end
   endtask

   function automatic logic [17:0] bundle();
      return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
              RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
              instr_done, illegal_op};
   endfunction

   initial begin
      int c;
      // reset held 3 cycles, everything forced low
      for (int i = 0; i < 3; i++) add(1'b0, 1'b1, RT, E_RST, 32'd0);
      // R-type 0x014B4820
      add(1'b1, 1'b1, RT,  E_FETCH_GO,   32'd0);
      add(1'b1, 1'b1, RT,  E_DECODE,     32'd0);
      add(1'b1, 1'b1, RT,  E_EXEC,       32'd0);
      add(1'b1, 1'b1, RT,  E_ALUWB,      32'd0);
      // lw 0x8D280004 with two wait cycles in MEMRD (mem_ready ignored in MEMADR/MEMWB)
      add(1'b1, 1'b1, LW,  E_FETCH_GO,   32'd1);
      add(1'b1, 1'b1, LW,  E_DECODE,     32'd1);
      add(1'b1, 1'b0, LW,  E_MEMADR,     32'd1);
      add(1'b1, 1'b0, LW,  E_MEMRD,      32'd1);
      add(1'b1, 1'b0, LW,  E_MEMRD,      32'd1);
      add(1'b1, 1'b1, LW,  E_MEMRD,      32'd1);
      add(1'b1, 1'b0, LW,  E_MEMWB,      32'd1);
      // sw 0xAD280004 with one FETCH wait and one MEMWR wait
      add(1'b1, 1'b0, SW,  E_FETCH_WAIT, 32'd2);
      add(1'b1, 1'b1, SW,  E_FETCH_GO,   32'd2);
      add(1'b1, 1'b1, SW,  E_DECODE,     32'd2);
      add(1'b1, 1'b1, SW,  E_MEMADR,     32'd2);
      add(1'b1, 1'b0, SW,  E_MEMWR_WAIT, 32'd2);
      add(1'b1, 1'b1, SW,  E_MEMWR_GO,   32'd2);
      // beq 0x112A0002
      add(1'b1, 1'b1, BEQ, E_FETCH_GO,   32'd3);
      add(1'b1, 1'b1, BEQ, E_DECODE,     32'd3);
      add(1'b1, 1'b0, BEQ, E_BRANCH,     32'd3);
      // illegal opcode 0x3F
      add(1'b1, 1'b1, BAD, E_FETCH_GO,   32'd4);
      add(1'b1, 1'b1, BAD, E_DECODE_ILL, 32'd4);
      add(1'b1, 1'b1, RT,  E_FETCH_GO,   32'd4);
      // opcode 000010
`ifdef MIPS_CTRL_JUMP_EN
      add(1'b1, 1'b1, JMP, E_DECODE,     32'd4);
      add(1'b1, 1'b1, JMP, E_JUMP,       32'd4);
      add(1'b1, 1'b1, RT,  E_FETCH_GO,   32'd5);
      c = 5;
`else
      add(1'b1, 1'b1, JMP, E_DECODE_ILL, 32'd4);
      add(1'b1, 1'b1, RT,  E_FETCH_GO,   32'd4);
      c = 4;
`endif
      // reset while stalled in MEMRD
      add(1'b1, 1'b1, LW,  E_DECODE,     c);
      add(1'b1, 1'b1, LW,  E_MEMADR,     c);
      add(1'b1, 1'b0, LW,  E_MEMRD,      c);
      add(1'b0, 1'b0, LW,  E_RST,        32'd0);
      add(1'b1, 1'b0, RT,  E_FETCH_WAIT, 32'd0);
      add(1'b1, 1'b1, SW,  E_FETCH_GO,   32'd0);
      // reset in MEMWR in the very cycle memory completes: no retire
      add(1'b1, 1'b1, SW,  E_DECODE,     32'd0);
      add(1'b1, 1'b1, SW,  E_MEMADR,     32'd0);
      add(1'b1, 1'b0, SW,  E_MEMWR_WAIT, 32'd0);
      add(1'b0, 1'b1, SW,  E_RST,        32'd0);
      add(1'b1, 1'b1, BEQ, E_FETCH_GO,   32'd0);
      add(1'b1, 1'b1, BEQ, E_DECODE,     32'd0);
      add(1'b1, 1'b1, BEQ, E_BRANCH,     32'd0);
      add(1'b1, 1'b1, RT,  E_FETCH_GO,   32'd1);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst_n     = vecs[i].rst;
         mem_ready = vecs[i].mr;
         opcode    = vecs[i].op;
         #1;
         chk("ctrl", i, {14'd0, bundle()}, {14'd0, vecs[i].exp});
         chk("retired_cnt", i, retired_cnt, vecs[i].cnt);
      end

      // wrap: 2-bit counter, beq loop (3 cycles each) with mem_ready=1
      begin
         int pulses;
         pulses = 0;
         @(negedge clk);
         rst_n2 = 1'b1;
         for (int i = 0; i < 9; i++) begin
            #1;
            if (w_done === 1'b1) pulses++;
            @(negedge clk);
         end
         #1;
         chk("wrap_pulses", 0, pulses, 32'd3);
         chk("wrap_cnt_full", 0, {30'd0, w_cnt}, 32'd3);
         @(negedge clk);
         @(negedge clk);
         #1;
         chk("wrap_done", 1, {31'd0, w_done}, 32'd1);
         chk("wrap_cnt_pre", 1, {30'd0, w_cnt}, 32'd3);
         @(negedge clk);
         #1;
         chk("wrap_cnt_zero", 2, {30'd0, w_cnt}, 32'd0);
         chk("wrap_done_after", 2, {31'd0, w_done}, 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
